universal_register: RTL

- Parametrised N-bit storage register with per-cycle mode select: hold, parallel load, shift, rotate, increment, clear.
- Successor to the single-bit load/hold register cell. Used as the general-purpose register and shift/count element in datapaths, e.g. the accumulator, address counter and serial converters.
- Adds a registered carry flag and serial in/out for chaining instances.

---
 rtl/ureg_pkg.sv | 17 +
 rtl/ureg_next.sv | 62 ++++++
 rtl/universal_register.sv | 57 +++++
 3 files changed

// File: rtl/ureg_pkg.sv
// Shared types for the universal register: operation select codes.
package ureg_pkg;

  localparam int unsigned MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    MODE_HOLD = 3'b000,
    MODE_LOAD = 3'b001,
    MODE_SHL  = 3'b010,
    MODE_SHR  = 3'b011,
    MODE_ROL  = 3'b100,
    MODE_ROR  = 3'b101,
    MODE_INC  = 3'b110,
    MODE_CLR  = 3'b111
  } mode_t;

endpackage

// File: rtl/ureg_next.sv
// Combinational next-state for the universal register: {carry', q'} from mode and current state.
module ureg_next
  import ureg_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          ARITH_SHR = 1'b0
) (
  input  mode_t              i_mode,
  input  logic [WIDTH-1:0]   i_q,
  input  logic [WIDTH-1:0]   i_d,
  input  logic               i_sin,
  input  logic               i_carry,
  output logic [WIDTH-1:0]   o_q_nxt,
  output logic               o_c_nxt
);

  logic w_fill;

  assign w_fill = ARITH_SHR ? i_q[WIDTH-1] : i_sin;

  always_comb begin
    o_q_nxt = i_q;
    o_c_nxt = i_carry;
    case (i_mode)
      MODE_HOLD: begin
        o_q_nxt = i_q;
        o_c_nxt = i_carry;
      end
      MODE_LOAD: begin
        o_q_nxt = i_d;
        o_c_nxt = 1'b0;
      end
      MODE_SHL: begin
        o_q_nxt = {i_q[WIDTH-2:0], i_sin};
        o_c_nxt = i_q[WIDTH-1];
      end
      MODE_SHR: begin
        o_q_nxt = {w_fill, i_q[WIDTH-1:1]};
        o_c_nxt = i_q[0];
      end
      MODE_ROL: begin
        o_q_nxt = {i_q[WIDTH-2:0], i_q[WIDTH-1]};
        o_c_nxt = i_q[WIDTH-1];
      end
      MODE_ROR: begin
        o_q_nxt = {i_q[0], i_q[WIDTH-1:1]};
        o_c_nxt = i_q[0];
      end
      // Carry-out of the increment lands only in the flag; q wraps.
      MODE_INC: {o_c_nxt, o_q_nxt} = {1'b0, i_q} + (WIDTH+1)'(1);
      MODE_CLR: begin
        o_q_nxt = '0;
        o_c_nxt = 1'b0;
      end
      default: begin
        o_q_nxt = i_q;
        o_c_nxt = i_carry;
      end
    endcase
  end

endmodule

// File: rtl/universal_register.sv
// N-bit register with hold/load/shift/rotate/increment/clear, registered carry and serial chaining outputs.
module universal_register
  import ureg_pkg::*;
#(
  parameter int unsigned      WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter bit               ARITH_SHR   = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic             carry,
  output logic             zero,
  output logic             sout_msb,
  output logic             sout_lsb
);

  logic [WIDTH-1:0] r_q;
  logic             r_carry;
  logic [WIDTH-1:0] w_q_nxt;
  logic             w_c_nxt;

  ureg_next #(
    .WIDTH     (WIDTH),
    .ARITH_SHR (ARITH_SHR)
  ) u_next (
    .i_mode  (mode_t'(mode)),
    .i_q     (r_q),
    .i_d     (d),
    .i_sin   (sin),
    .i_carry (r_carry),
    .o_q_nxt (w_q_nxt),
    .o_c_nxt (w_c_nxt)
  );

  // rst is active-low despite its name.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q     <= RESET_VALUE;
      r_carry <= 1'b0;
    end else if (en) begin
      r_q     <= w_q_nxt;
      r_carry <= w_c_nxt;
    end
  end

  assign q        = r_q;
  assign carry    = r_carry;
  assign zero     = (r_q == '0);
  assign sout_msb = r_q[WIDTH-1];
  assign sout_lsb = r_q[0];

endmodule
